// File: rtl/rx_char_buffer.sv
// -----------------------------------------------------------------------------
// rx_char_buffer
//
// Receive-side serial-to-parallel buffer for the UART receiver. Serial bits
// are shifted in on each rising edge of the SRclk strobe. A rising edge of
// charReceived marks the frame as complete: the frame is checked for framing
// errors and {frameErr, data} is queued in a small show-ahead FIFO. The
// processor pops one byte per read pulse.
//
// Frame layout, first bit received first:
//   start(0), DATA_W data bits LSB first, [even parity], stop(1)
//
// Optional feature macro: RX_PARITY_EN
//   When defined, the frame carries an even-parity bit before the stop bit.
//   A sticky parityErr output is added. The byte is queued even when the
//   parity check fails.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   bitStream    in   serial receive line (clk domain)
//   SRclk        in   shift strobe level; a rising edge samples bitStream
//   charReceived in   frame-complete level; a rising edge captures the frame
//   read         in   processor pop strobe
//   clearStatus  in   clears the sticky overrun (and parityErr) flags
//   dataOut      out  head-of-FIFO data byte, 0 when empty
//   frameErrOut  out  framing-error tag of the head entry, 0 when empty
//   dataValid    out  FIFO not empty
//   full         out  FIFO holds DEPTH entries
//   overrun      out  sticky: a character was dropped because FIFO was full
//   parityErr    out  (RX_PARITY_EN only) sticky parity error
// -----------------------------------------------------------------------------
module rx_char_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bitStream,
  input  logic              SRclk,
  input  logic              charReceived,
  input  logic              read,
  input  logic              clearStatus,
  output logic [DATA_W-1:0] dataOut,
  output logic              frameErrOut,
  output logic              dataValid,
  output logic              full,
  output logic              overrun
`ifdef RX_PARITY_EN
  ,
  output logic              parityErr
`endif
);

`ifdef RX_PARITY_EN
  localparam int FRAME_W = DATA_W + 3;
`else
  localparam int FRAME_W = DATA_W + 2;
`endif
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + 1;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic               r_sr_prev;
  logic               r_cr_prev;
  logic [FRAME_W-1:0] r_sr;
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic               r_overrun;
  logic [EW-1:0]      r_mem [DEPTH];

  logic               w_shift;
  logic               w_cap;
  logic [FRAME_W-1:0] w_sr_next;
  logic [DATA_W-1:0]  w_data;
  logic               w_ferr;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;

  // Edge detection on the level strobes
  assign w_shift = SRclk & ~r_sr_prev;
  assign w_cap   = charReceived & ~r_cr_prev;

  // A shift in the capture cycle is applied before the fields are extracted.
  assign w_sr_next = w_shift ? {bitStream, r_sr[FRAME_W-1:1]} : r_sr;
  assign w_data    = w_sr_next[DATA_W:1];
  assign w_ferr    = w_sr_next[0] | ~w_sr_next[FRAME_W-1];

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_pop   = read & ~w_empty;
  // A pop in the same cycle frees a slot, so a capture while full is
  // still accepted in that case.
  assign w_push  = w_cap & (~w_full | w_pop);
  assign w_drop  = w_cap & w_full & ~w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr_prev <= 1'b0;
      r_cr_prev <= 1'b0;
      r_sr      <= '0;
    end else begin
      r_sr_prev <= SRclk;
      r_cr_prev <= charReceived;
      if (w_shift) begin
        r_sr <= w_sr_next;
      end else if (w_cap) begin
        r_sr <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage carries no reset; outputs are gated by dataValid instead.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {w_ferr, w_data};
  end

  // Set beats clear when a drop coincides with clearStatus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clearStatus) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef RX_PARITY_EN
  logic r_parity_err;
  logic w_par_fail;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign w_par_fail = ^{w_data, w_sr_next[DATA_W+1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity_err <= 1'b0;
    end else if (w_cap && w_par_fail) begin
      r_parity_err <= 1'b1;
    end else if (clearStatus) begin
      r_parity_err <= 1'b0;
    end
  end

  assign parityErr = r_parity_err;
`endif

  assign dataValid   = ~w_empty;
  assign full        = w_full;
  assign overrun     = r_overrun;
  assign dataOut     = w_empty ? '0 : r_mem[r_rptr][DATA_W-1:0];
  assign frameErrOut = w_empty ? 1'b0 : r_mem[r_rptr][DATA_W];

endmodule

// File: doc/rx_char_buffer.md
# rx_char_buffer

Receive-side serial-to-parallel buffer for the UART receiver, directly downstream of the character bit-count controller. It shifts in `bitStream` on every shift-clock strobe (`SRclk`), assembles a complete frame when `charReceived` asserts, checks framing and queues the data byte in a small show-ahead FIFO. The microprocessor pops bytes through a read-strobe handshake.

## Interface
- `DATA_W`, 8, data bits per character (frame = start + `DATA_W` data bits LSB first + stop).
- `DEPTH`, 4, FIFO depth in characters; must be a power of two, at least 2.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `bitStream`  input  1  serial receive line, synchronous to `clk`.
- `SRclk`  input  1  shift strobe from bit-count controller (level, `clk` domain); a rising edge means sample now.
- `charReceived`  input  1  frame-complete indication (level, `clk` domain); a rising edge means the frame is complete.
- `read`  input  1  processor pop strobe, one pulse per byte.
- `clearStatus`  input  1  clears sticky `overrun` (and `parityErr` when compiled in).
- `dataOut`  output  `DATA_W`  head-of-FIFO data byte (show-ahead).
- `frameErrOut`  output  1  framing-error tag of head entry.
- `dataValid`  output  1  FIFO not empty.
- `full`  output  1  FIFO holds `DEPTH` entries.
- `overrun`  output  1  sticky: a character was dropped because the FIFO was full.

## Operation
- Edge detect: registered copies `srPrev` and `crPrev`. Shift event is `SRclk & ~srPrev`; capture event is `charReceived & ~crPrev`.
- Shift register `FRAME_W` = `DATA_W`+2 bits (`+3` with parity). On a shift event: `sr <= {bitStream, sr[FRAME_W-1:1]}`. The first bit received ends in `sr[0]`.
- On a capture event, fields come from the post-shift value of `sr` (a same-cycle shift is applied first):
  - start = bit 0
  - data = bits `DATA_W:1`
  - stop = MSB
- Framing error = (start != 0) or (stop != 1). The entry pushed is `{frameErr, data}`.
- The capture event clears the shift register to 0 on the following edge, unless a shift event occurs in that cycle.
- FIFO: circular buffer with `log2(DEPTH)`-bit read and write pointers and a `log2(DEPTH)+1`-bit count.
  - Push on capture; pop on `read & dataValid`.
  - A read while empty is ignored, with no state change.
- Full FIFO handling:
  - Capture while full with no pop in the same cycle: the character is dropped, `overrun` is set, and pointers are unchanged.
  - Capture and pop in the same cycle while full: the pop is performed and the push is accepted, so `overrun` is not set and the count is unchanged.
- Capture and pop in the same cycle with a non-empty FIFO: count is unchanged and both pointers advance.
- `clearStatus` clears the sticky flags. If `clearStatus` coincides with a new overrun, the flag ends set (the set wins).
- Pointers wrap modulo `DEPTH`.

## Timing
- Reset values (asynchronous, immediate):
  - `dataOut`=0, `frameErrOut`=0, `dataValid`=0, `full`=0, `overrun`=0
  - shift register, pointers, count, `srPrev`, `crPrev` all 0
- Shift: `bitStream` is sampled at the same edge where the `SRclk` rise is seen (1-cycle edge-detect latency from the `SRclk` level).
- Capture into an empty FIFO: `dataValid` and `dataOut` update 1 cycle after the edge where the `charReceived` rise is seen.
- Pop: `dataOut` shows the next entry 1 cycle after the `read` edge. `dataValid` drops in that same cycle if the FIFO is now empty.
- A `charReceived` or `SRclk` level held high for many cycles produces exactly one event.
- Reset asserted mid-frame discards the partial frame and all queued bytes. After release, the first `SRclk` rise starts a fresh frame.

## Configuration
- `RX_PARITY_EN` defined:
  - Frame is start + data + even-parity bit + stop; `FRAME_W` = `DATA_W`+3.
  - Parity bit is `sr[DATA_W+1]`.
  - Adds output `parityErr  output  1`: sticky flag, set on capture when the XOR of data and the parity bit is 1, cleared by `clearStatus` and by reset. Reset value 0.
  - The byte is still queued when parity fails.
- `RX_PARITY_EN` undefined: 10-bit frame, no parity logic, no `parityErr` port.

## Test plan
- Reset then frame 0xA5: bits 0,1,0,1,0,0,1,0,1,1 on ten `SRclk` pulses, then a `charReceived` rise. Required: `dataValid`=1 one cycle later, `dataOut`=0xA5, `frameErrOut`=0.
- Frame 0x3C with stop bit 0. Required: `dataOut`=0x3C, `frameErrOut`=1, and a subsequent good frame 0x00 queues with `frameErrOut`=0.
- Five frames 0x01..0x05 with no reads (`DEPTH`=4). Required: `full`=1 after the fourth, `overrun`=1 after the fifth. Reads return 0x01..0x04, then `dataValid`=0. `clearStatus` gives `overrun`=0.
- FIFO full, `read` pulsed in the same cycle as a capture of 0x77. Required: `overrun` stays 0, `full` stays 1, fourth pop returns 0x77.
- Reset pulsed after 5 of 10 bits. Required: all outputs 0. The next full frame 0x5A is received as 0x5A with `frameErrOut`=0.
- With `RX_PARITY_EN`, frame 0x07 with parity bit 0. Required: `parityErr`=1 and `dataOut`=0x07. Frame 0x07 with parity 1 gives no new error after `clearStatus`.
